// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode and datapath-select encodings shared by the multicycle control unit.
package mc_ctrl_pkg;
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_I_EXEC    = 4'd10,
      S_I_WB      = 4'd11
   } state_t;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] SRCB_B   = 2'b00;
   localparam logic [1:0] SRCB_ONE = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;
   localparam logic [1:0] PCSRC_INC    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_ALU    = 2'b11;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational output decode from state, gated by mem_ready in FETCH and zero in BRANCH.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [3:0] state,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic [1:0] pc_source,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op
);
   always_comb begin
      pcwrite    = 1'b0;
      pc_source  = PCSRC_INC;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_op     = ALU_ADD;
      case (state)
         S_FETCH: begin
            mem_read = 1'b1;
            ir_write = mem_ready;
            pcwrite  = mem_ready;
         end
         S_DECODE: alu_src_b = SRCB_IMM;
         S_MEM_ADDR, S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_source = PCSRC_ALUOUT;
            pcwrite   = zero;
         end
         S_JUMP: begin
            pcwrite   = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         S_I_WB: reg_write = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control sequencer; holds state, next-state logic and the sticky illegal_op flag.
module mc_control_fsm
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic [1:0] pc_source,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [3:0] state,
   output logic       illegal_op
);
   state_t state_q, state_d;
   logic   op_bad;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         illegal_op <= 1'b0;
      end else begin
         state_q <= state_d;
         if (op_bad) illegal_op <= 1'b1;
      end
   end
   always_comb begin
      state_d = S_FETCH;
      op_bad  = 1'b0;
      case (state_q)
         S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_R:         state_d = S_R_EXEC;
               OP_ADDI:      state_d = S_I_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default:      op_bad  = 1'b1;
            endcase
         S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_R_EXEC:    state_d = S_R_WB;
         S_I_EXEC:    state_d = S_I_WB;
         default:     state_d = S_FETCH;
      endcase
   end
   assign state = state_q;
   mc_ctrl_decode u_decode (
      .state      (state_q),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pcwrite    (pcwrite),
      .pc_source  (pc_source),
      .ir_write   (ir_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .iord       (iord),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op)
   );
endmodule
